// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 opcodes,
// FSM state encoding and the operand signedness helpers.
package mdu_pkg;

  localparam int MDU_N     = 32;
  localparam int MDU_CNT_W = $clog2(MDU_N);

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_ADJ
  } mdu_state_t;

  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface mdu_sequencer_if #(parameter int N = mdu_pkg::MDU_N);

  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  modport master (output start, op, a, b, flush, input busy, done, result);
  modport slave  (input start, op, a, b, flush, output busy, done, result);

endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
module mdu_step #(
  parameter int N = 32
) (
  input  logic           is_div,
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   opnd,
  output logic [2*N-1:0] acc_next,
  output logic           flag
);

  logic [N:0]   sum;
  logic [N:0]   rem_sh;
  logic [N-1:0] diff;
  logic         borrow;

  // The divide quotient bit is left at zero here; the sequencer inserts it
  // from the borrow flag so both modes expose their carry/borrow the same way.
  always_comb begin
    sum      = {1'b0, acc[2*N-1:N]} + {1'b0, opnd & {N{acc[0]}}};
    rem_sh   = {acc[2*N-1:N], acc[N-1]};
    borrow   = rem_sh < {1'b0, opnd};
    diff     = rem_sh[N-1:0] - opnd;
    acc_next = {sum, acc[N-1:1]};
    flag     = sum[N];
    if (is_div) begin
      acc_next = {(borrow ? rem_sh[N-1:0] : diff), acc[N-2:0], 1'b0};
      flag     = borrow;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit: accepts one op per start, holds busy for
// N+1 cycles (1 for divide special cases), then pulses done with a registered result.
module mdu_sequencer
  import mdu_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mdu_sequencer_if.slave bus
);

  localparam int N = MDU_N;
  localparam logic [MDU_CNT_W-1:0] CNT_LAST = MDU_CNT_W'(N - 1);

  mdu_state_t           state;
  logic [2:0]           op_q;
  logic [2*N-1:0]       acc;
  logic [N-1:0]         opnd;
  logic                 neg_q;
  logic                 neg_r;
  logic                 special;
  logic [MDU_CNT_W-1:0] cnt;
  logic                 busy_q;
  logic                 done_q;
  logic [N-1:0]         result_q;

  logic                 sa;
  logic                 sb;
  logic [N-1:0]         mag_a;
  logic [N-1:0]         mag_b;
  logic                 is_special;
  logic [N-1:0]         preset;
  logic [2*N-1:0]       prod;
  logic [N-1:0]         quo_fix;
  logic [N-1:0]         rem_fix;
  logic [N-1:0]         adj_result;
  logic [2*N-1:0]       step_acc;
  logic                 step_flag;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Request decode: operand magnitudes plus the divide-by-zero / overflow shortcuts.
  always_comb begin
    sa         = op_signed_a(bus.op) & bus.a[N-1];
    sb         = op_signed_b(bus.op) & bus.b[N-1];
    mag_a      = sa ? -bus.a : bus.a;
    mag_b      = sb ? -bus.b : bus.b;
    is_special = 1'b0;
    preset     = '1;
    if (bus.op[2] && (bus.b == '0)) begin
      is_special = 1'b1;
      preset     = bus.op[1] ? bus.a : '1;
    end else if (op_signed_b(bus.op) && bus.op[2] &&
                 (bus.a == {1'b1, {(N-1){1'b0}}}) && (bus.b == '1)) begin
      is_special = 1'b1;
      preset     = bus.op[1] ? '0 : bus.a;
    end
  end

  always_comb begin
    prod    = neg_q ? -acc : acc;
    quo_fix = neg_q ? -acc[N-1:0] : acc[N-1:0];
    rem_fix = neg_r ? -acc[2*N-1:N] : acc[2*N-1:N];
    if (special) begin
      adj_result = acc[N-1:0];
    end else if (op_q[2]) begin
      adj_result = op_q[1] ? rem_fix : quo_fix;
    end else begin
      adj_result = (op_q == MDU_MUL) ? prod[N-1:0] : prod[2*N-1:N];
    end
  end

  mdu_step #(.N(N)) u_step (
    .is_div   (op_q[2]),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (step_acc),
    .flag     (step_flag)
  );

  // Multiplier (or dividend) rides in the low half of acc; the high half
  // accumulates the partial product (or partial remainder).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MDU_IDLE;
      op_q     <= MDU_MUL;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      special  <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state  <= MDU_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          MDU_IDLE: begin
            if (bus.start) begin
              op_q    <= bus.op;
              opnd    <= mag_b;
              neg_q   <= sa ^ sb;
              neg_r   <= sa;
              cnt     <= '0;
              busy_q  <= 1'b1;
              special <= is_special;
              if (is_special) begin
                acc   <= {{N{1'b0}}, preset};
                state <= MDU_ADJ;
              end else begin
                acc   <= {{N{1'b0}}, mag_a};
                state <= MDU_CALC;
              end
            end
          end
          MDU_CALC: begin
            acc <= op_q[2] ? {step_acc[2*N-1:1], ~step_flag} : step_acc;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state <= MDU_ADJ;
            end
          end
          MDU_ADJ: begin
            result_q <= adj_result;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= MDU_IDLE;
          end
          default: state <= MDU_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer: arithmetic results, latency,
// back-to-back issue, ignored starts, flush and reset aborts.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  always #5 clk = ~clk;

  mdu_sequencer_if bus ();

  mdu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.done === 1'b1) done_seen++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    step_cycle();
    bus.start = 1'b0;
  endtask

  // Leaves the bench in the done cycle, so a following call issues back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int m;
    apply_stimulus(op, a, b);
    m = 1;
    check_output({tag, " busy"}, 64'(bus.busy), 64'd1);
    while (bus.done !== 1'b1 && m < 100) begin
      step_cycle();
      m++;
    end
    check_output({tag, " latency"}, 64'(m), 64'(exp_lat));
    check_output({tag, " result"}, 64'(bus.result), 64'(exp));
    check_output({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int m;
    int s;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) step_cycle();
    check_output("reset busy", 64'(bus.busy), 64'd0);
    check_output("reset done", 64'(bus.done), 64'd0);
    check_output("reset result", 64'(bus.result), 64'd0);
    rst = 1'b0;
    step_cycle();

    run_op("mul",    MDU_MUL,    32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 34);
    run_op("mulh",   MDU_MULH,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("mulhu",  MDU_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 34);
    run_op("mulhsu", MDU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("mulh_min",  MDU_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu_min", MDU_MULHU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mul_2p32",   MDU_MUL,   32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 34);
    run_op("mulhu_2p32", MDU_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34);

    run_op("div_m7_2",  MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",  MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_7_2",  MDU_DIVU, 32'd7, 32'd2, 32'd3, 34);
    run_op("remu_7_2",  MDU_REMU, 32'd7, 32'd2, 32'd1, 34);
    run_op("div_100_m7", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
    run_op("rem_100_m7", MDU_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 34);
    run_op("rem_m100_7", MDU_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
    run_op("divu_big",  MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
    run_op("remu_big",  MDU_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 34);

    run_op("divu_by0", MDU_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("rem_by0",  MDU_REM,  32'h1234, 32'd0, 32'h0000_1234, 2);
    run_op("div_by0",  MDU_DIV,  32'h1234, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("remu_by0", MDU_REMU, 32'h1234, 32'd0, 32'h0000_1234, 2);
    run_op("div_ovf",  MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf",  MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);

    // A start pulse while busy must not queue a second operation.
    step_cycle();
    s = done_seen;
    apply_stimulus(MDU_DIVU, 32'd7, 32'd2);
    m = 1;
    repeat (4) begin step_cycle(); m++; end
    bus.op = MDU_MUL; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
    step_cycle(); m++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && m < 100) begin step_cycle(); m++; end
    check_output("ign_start latency", 64'(m), 64'd34);
    check_output("ign_start result", 64'(bus.result), 64'd3);
    repeat (40) step_cycle();
    check_output("ign_start done_count", 64'(done_seen - s), 64'd1);
    check_output("ign_start busy", 64'(bus.busy), 64'd0);

    // Flush at the tenth CALC cycle.
    apply_stimulus(MDU_DIVU, 32'd100, 32'd7);
    repeat (9) step_cycle();
    bus.flush = 1'b1;
    step_cycle();
    bus.flush = 1'b0;
    check_output("flush busy", 64'(bus.busy), 64'd0);
    s = done_seen;
    repeat (40) step_cycle();
    check_output("flush done_count", 64'(done_seen - s), 64'd0);
    check_output("flush result_kept", 64'(bus.result), 64'd3);

    bus.op = MDU_MUL; bus.a = 32'd3; bus.b = 32'd3;
    bus.start = 1'b1; bus.flush = 1'b1;
    step_cycle();
    bus.start = 1'b0; bus.flush = 1'b0;
    check_output("flush_prio busy", 64'(bus.busy), 64'd0);
    repeat (40) step_cycle();
    check_output("flush_prio done_count", 64'(done_seen - s), 64'd0);

    // Reset mid-CALC clears every output.
    apply_stimulus(MDU_MULHU, 32'hFFFF_FFFF, 32'd2);
    repeat (9) step_cycle();
    rst = 1'b1;
    step_cycle();
    check_output("rst_mid busy", 64'(bus.busy), 64'd0);
    check_output("rst_mid done", 64'(bus.done), 64'd0);
    check_output("rst_mid result", 64'(bus.result), 64'd0);
    rst = 1'b0;
    step_cycle();
    run_op("after_rst", MDU_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the RV32M extension in the EX stage. It accepts one M-type operation per `start` pulse and runs a radix-2 shift-add multiply or restoring divide over N cycles through an internal add/sub step. It raises `busy` so the hazard logic stalls IF/ID/EX, then returns a registered result with a one-cycle `done` pulse. The single-cycle ALU stays free for non-M instructions; this block owns every M-extension result.

## Interface
- `N`, 32: operand/result width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`, `b`  in  N  rs1/rs2 operands; sampled with `start`
- `flush`  in  1  pipeline kill; aborts any operation
- `busy`  out  1  high from accept edge until the edge that asserts `done`
- `done`  out  1  one-cycle pulse; `result` valid
- `result`  out  N  held from `done` until the next accepted `done`

## Operation
- States: IDLE, CALC, ADJ.
- IDLE + `start` (and no `flush`):
  - Latch `op`, then latch |a| and |b| per signedness:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: only `a` signed.
    - Others: both unsigned.
  - Record `neg_q = sa^sb` and `neg_r = sa`.
  - Clear the 2N-bit accumulator, set `cnt = 0`, set `busy`.
- Special divide cases go IDLE→ADJ directly with a preset result:
  - `b == 0`: DIV/DIVU → all-ones; REM/REMU → `a`.
  - DIV/REM with `a = 0x8000_0000` and `b = 0xFFFF_FFFF`: DIV → `0x8000_0000`; REM → 0.
- CALC runs one iteration per cycle, `cnt` 0..N-1, then goes to ADJ.
  - Multiply: if multiplier LSB is set, add multiplicand to the upper half, then shift right 1. The carry-out is kept (N+1-bit add).
  - Divide: shift {rem, quo} left 1 and compute trial `rem - divisor`. If there is no borrow, keep the difference and set the quotient LSB.
- ADJ (one cycle):
  - Multiply: negate the 2N-bit product if `neg_q`. MUL selects bits [N-1:0]; the others select [2N-1:N].
  - Divide: negate the quotient if `neg_q` (signed ops), negate the remainder if `neg_r` (signed ops).
  - Register `result`, assert `done`, clear `busy`, return to IDLE.
- `start` while busy is ignored; no queueing.
- `flush` (any state) → IDLE next edge. Effects: `busy` = 0, no `done`, `result` unchanged. `flush` has priority over `start`.
- `rst`: state IDLE, `busy` = 0, `done` = 0, `result` = 0, `cnt` = 0, accumulators = 0.

## Timing
- Accept at edge k, normal path:
  - `busy` is high in cycles k+1 .. k+N+1.
  - `done` = 1 in cycle k+N+2 (34 cycles after accept for N=32).
  - `busy` = 0 in the `done` cycle.
- Special-case path: `done` = 1 in cycle k+2.
- `done` is high only while in IDLE. A `start` in the `done` cycle is accepted, giving back-to-back issue with no bubble.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `rst` mid-operation follows the same rules as `flush`, plus it clears `result`.

## Structure
- Shared package `mdu_pkg`:
  - funct3 op localparams (`MDU_MUL` … `MDU_REMU`)
  - state encoding (`MDU_IDLE`, `MDU_CALC`, `MDU_ADJ`)
  - `MDU_CNT_W = $clog2(N)`
- One sub-module, `mdu_step`: combinational single iteration.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator, plus the borrow/carry.
  - The FSM, counter and sign fix-up stay in `mdu_sequencer`.

## Test plan
- Signed/unsigned multiply, `a = 0xFFFF_FFFF`, `b = 2`:
  - MUL → `0xFFFF_FFFE`
  - MULH → `0xFFFF_FFFF`
  - MULHU → `0x0000_0001`
  - MULHSU → `0xFFFF_FFFF`
  - `done` exactly 34 cycles after accept.
- Signed divide, `a = -7`, `b = 2`: DIV → `0xFFFF_FFFD` (-3), REM → `0xFFFF_FFFF` (-1). DIVU `7/2` → 3, REMU → 1.
- Divide-by-zero, `a = 0x1234`, `b = 0`: DIVU → `0xFFFF_FFFF`, REM → `0x1234`. Overflow case `0x8000_0000 / -1`: DIV → `0x8000_0000`, REM → 0. All with `done` 2 cycles after accept.
- Back-to-back issue: `start` in the `done` cycle is accepted. A `start` pulse while busy produces no extra `done`.
- Abort: `flush` at cycle 10 of CALC → `busy` low next cycle, no `done`, prior `result` unchanged. `rst` mid-CALC → all outputs 0.
